// File: rtl/fsm_tick_pkg.sv
// Shared state type, tick period and successor function for the tick FSMs.
package fsm_tick_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } tick_state_t;

  localparam int TICK_PERIOD = 4;

  // The state that raises the tick is the last one before wrapping.
  localparam tick_state_t LAST_STATE = tick_state_t'(2'(TICK_PERIOD - 1));

  function automatic tick_state_t succ(input tick_state_t s);
    tick_state_t n;
    case (s)
      S0:      n = S1;
      S1:      n = S2;
      S2:      n = S3;
      S3:      n = S0;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fsm_tick_core.sv
// One Moore tick FSM: advances while en is high, collapses to S0 when en is low.
module fsm_tick_core
  import fsm_tick_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  tick_state_t state;
  tick_state_t state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // A low enable restarts the count instead of holding it.
  always_comb begin
    state_next = S0;
    if (en) begin
      state_next = succ(state);
    end
  end

  assign tick = (state == LAST_STATE);

endmodule

// File: rtl/fsm_tick_unit.sv
// Free-running and enable-gated period-4 tick generators sharing clock and reset.
module fsm_tick_unit
  import fsm_tick_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic A,
  output logic tick,
  output logic tick_en
);

  fsm_tick_core u_free (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .tick  (tick)
  );

  fsm_tick_core u_gated (
    .clk   (clk),
    .reset (reset),
    .en    (A),
    .tick  (tick_en)
  );

endmodule

// File: tb/tb_fsm_tick_unit.sv
// Directed self-checking bench for fsm_tick_unit; outputs are sampled on the falling edge.
module tb_fsm_tick_unit;

  logic clk = 1'b0;
  logic reset;
  logic A;
  logic tick;
  logic tick_en;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  fsm_tick_unit dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .tick    (tick),
    .tick_en (tick_en)
  );

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0b, expected %0b", tag, observed, expected);
    end
  endtask

  // Drive inputs at the falling edge, then advance through one rising edge.
  task automatic applyStimulus(input logic reset_v, input logic a_v);
    reset = reset_v;
    A     = a_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    A     = 1'b0;

    #2;
    checkOutput("reset_t0_tick", tick, 1'b0);
    checkOutput("reset_t0_tick_en", tick_en, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("reset_tick_%0d", k), tick, 1'b0);
      checkOutput($sformatf("reset_tick_en_%0d", k), tick_en, 1'b0);
    end

    // Lockstep: edges 1..10 after release, ticks after edges 3 and 7.
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("lock_tick_%0d", e), tick, logic'(e % 4 == 3));
      checkOutput($sformatf("lock_tick_en_%0d", e), tick_en, logic'(e % 4 == 3));
    end

    // Disable at edges 11..13: gated path sits in S0.
    for (int e = 11; e <= 13; e++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("dis_tick_%0d", e), tick, logic'(e % 4 == 3));
      checkOutput($sformatf("dis_tick_en_%0d", e), tick_en, 1'b0);
    end

    // Re-enable at edges 14..23: gated path restarts from S0 at edge 14.
    for (int e = 14; e <= 23; e++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("reen_tick_%0d", e), tick, logic'(e % 4 == 3));
      checkOutput($sformatf("reen_tick_en_%0d", e), tick_en, logic'((e - 13) % 4 == 3));
    end

    // Edge 24 puts the gated path in S3, then A drops while in S3.
    applyStimulus(1'b0, 1'b1);
    checkOutput("s3_tick_en", tick_en, 1'b1);
    checkOutput("s3_tick", tick, 1'b0);
    A = 1'b0;
    #1;
    checkOutput("s3_a_low_moore", tick_en, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("s3_exit_tick_en", tick_en, 1'b0);
    checkOutput("s3_exit_tick", tick, 1'b0);

    // Edges 26,27: free path reaches S3, gated path reaches S2.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pre_rst_tick", tick, 1'b1);
    checkOutput("pre_rst_tick_en", tick_en, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_mid_tick", tick, 1'b0);
    checkOutput("async_mid_tick_en", tick_en, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_hold_tick", tick, 1'b0);
    checkOutput("rst_hold_tick_en", tick_en, 1'b0);

    // Restart after reset: both paths in phase.
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("restart_tick_%0d", e), tick, logic'(e % 4 == 3));
      checkOutput($sformatf("restart_tick_en_%0d", e), tick_en, logic'(e % 4 == 3));
    end

    // Both outputs high now; a mid-cycle reset must clear them at once.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_s3_tick", tick, 1'b0);
    checkOutput("async_s3_tick_en", tick_en, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
